// File: rtl/stream_dram_writer.sv
// Sample stream -> FIFO -> Avalon-MM DDR3 writer, one-shot or ring capture.
// Ports: clk/rst_n, csr_* CSR slave, ddr_* write master, d_in stream, done.
module stream_dram_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        csr_addr,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_write,
  output logic [DATA_W-1:0] ddr_writedata,
  input  logic              ddr_waitrequest,
  input  logic [DATA_W-1:0] d_in,
  input  logic              d_in_valid,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q, step_q, addr_q;
  logic [31:0]       len_q, cnt_q, acc_q, rdata_q, rd_d;
  logic              circ_q, pend_q;
  logic              done_q, ovf_q, wrap_q, abrt_q;
  logic [PW:0]       wptr_q, rptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic busy, empty, full, xfer, last;
  logic ctl_wr, do_start, do_abort;
  logic want_push, push;

  assign busy  = (state_q == RUN) || (state_q == FLUSH);
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                 (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  // In FLUSH only a write already on the bus at abort time is finished.
  assign ddr_write = ((state_q == RUN) && !empty) ||
                     ((state_q == FLUSH) && pend_q);
  assign ddr_addr  = addr_q;
  assign ddr_writedata = ddr_write ? mem_q[rptr_q[PW-1:0]] : '0;
  assign xfer = ddr_write && !ddr_waitrequest;
  assign last = (cnt_q + 32'd1) == len_q;

  assign ctl_wr   = csr_write && (csr_addr == 3'd3);
  assign do_start = ctl_wr && csr_writedata[0] && !busy;
  assign do_abort = ctl_wr && csr_writedata[2] && (state_q == RUN);

  assign want_push = (state_q == RUN) && !do_abort && d_in_valid &&
                     (circ_q || (acc_q < len_q));
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push = want_push && (!full || xfer);

  assign csr_readdata = rdata_q;
  assign done = done_q;

  always_comb begin
    rd_d = 32'hDEAD_BEEF;
    case (csr_addr)
      3'd0: rd_d = 32'(base_q);
      3'd1: rd_d = len_q;
      3'd2: rd_d = 32'(step_q);
      3'd3: rd_d = 32'd0;
      3'd4: rd_d = {27'd0, abrt_q, wrap_q, ovf_q, done_q, busy};
      3'd5: rd_d = cnt_q;
      default: rd_d = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      step_q  <= ADDR_W'(1);
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      circ_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wrap_q  <= 1'b0;
      abrt_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      rdata_q <= csr_read ? rd_d : 32'd0;
      if (csr_write && !busy) begin
        case (csr_addr)
          3'd0: base_q <= ADDR_W'(csr_writedata);
          3'd1: len_q  <= csr_writedata;
          3'd2: step_q <= ADDR_W'(csr_writedata);
          default: ;
        endcase
      end
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        acc_q  <= acc_q + 32'd1;
      end
      if (want_push && !push) ovf_q <= 1'b1;
      if (xfer) begin
        rptr_q <= rptr_q + 1'b1;
        addr_q <= addr_q + step_q;
        cnt_q  <= cnt_q + 32'd1;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (do_start) begin
            circ_q <= csr_writedata[1];
            addr_q <= base_q;
            cnt_q  <= '0;
            acc_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            wrap_q <= 1'b0;
            abrt_q <= 1'b0;
            done_q <= (len_q == 32'd0);
            state_q <= (len_q == 32'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (do_abort) begin
            state_q <= FLUSH;
            pend_q  <= ddr_write && ddr_waitrequest;
          end else if (xfer && last) begin
            if (circ_q) begin
              addr_q <= base_q;
              cnt_q  <= '0;
              acc_q  <= '0;
              wrap_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!pend_q || xfer) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            abrt_q  <= 1'b1;
            done_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/stream_dram_writer.md
# stream_dram_writer

Parametrised successor to the single-shot DDR3 stream writer. Captures a sample stream (with valid qualifier) into an internal FIFO and writes it to DDR3 through an Avalon-MM master port that fully honours `ddr_waitrequest`, with one-shot or circular (ring-buffer) capture, abort, and overflow detection. Sits between the demodulator sample path and the DDR3 controller, configured by the HPS/Nios over a 32-bit Avalon-MM CSR slave; everything runs on one clock.

## Interface
- `DATA_W`, 16: sample and `ddr_writedata` width.
- `ADDR_W`, 32: DDR address width.
- `FIFO_DEPTH`, 16: sample FIFO entries, power of two, ≥ 4.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `csr_addr` in 3: CSR word address.
- `csr_read` in 1: CSR read strobe.
- `csr_write` in 1: CSR write strobe.
- `csr_writedata` in 32: CSR write data.
- `csr_readdata` out 32: CSR read data, registered.
- `ddr_addr` out ADDR_W: DDR write address.
- `ddr_write` out 1: DDR write request.
- `ddr_writedata` out DATA_W: DDR write data.
- `ddr_waitrequest` in 1: DDR stall.
- `d_in` in DATA_W: stream sample.
- `d_in_valid` in 1: sample qualifier; no backpressure.
- `done` out 1: mirror of status.done.

## Operation
- CSR map: 0 base (ADDR_W), 1 length in samples (32b), 2 step (ADDR_W), 3 control (write-only: bit0 start, bit1 circular, bit2 abort), 4 status (bit0 busy, bit1 done, bit2 overflow, bit3 wrapped, bit4 aborted), 5 sample count (completed DDR writes). Unmapped reads return 0xDEADBEEF.
- Writes to regs 0–2 while busy are ignored; start while busy ignored; abort while idle ignored.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start: latch mode = bit1; addr ← base; count ← 0; accepted ← 0; FIFO cleared; done/overflow/wrapped/aborted cleared. Length 0 → DONE (done=1) directly; else → RUN.
- RUN, input: sample pushed when `d_in_valid` and (circular or accepted < length). Push while FIFO full drops the sample and sets overflow (sticky); dropped samples don't count as accepted.
- RUN, output: FIFO head presented on `ddr_writedata`, `ddr_addr` = current addr, `ddr_write`=1 while FIFO non-empty. Transfer completes on a cycle with `ddr_write`=1 and `ddr_waitrequest`=0; then pop, addr ← addr + step (mod 2^ADDR_W), count ← count+1.
- One-shot: completion making count == length → DONE, `ddr_write`=0, done=1.
- Circular: completion making count == length → addr ← base, count ← 0, accepted ← 0, wrapped=1 (sticky); stays in RUN.
- Abort in RUN → FLUSH: input acceptance stops immediately; an asserted `ddr_write` is held with addr/data stable until accepted; FIFO then discarded; → IDLE, aborted=1, done=0.
- While `ddr_write`=1 and `ddr_waitrequest`=1, `ddr_addr`, `ddr_writedata`, `ddr_write` must not change, regardless of abort or CSR activity.
- busy = state ∈ {RUN, FLUSH}.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; `ddr_write`=0, `ddr_addr`=0, `ddr_writedata`=0, `csr_readdata`=0, `done`=0; base=0, length=0, step=1, all status bits 0.
- CSR read latency 1 cycle; `csr_readdata`=0 on cycles after no read.
- Start takes effect the cycle after the CSR write; RUN entered next edge.
- Sample pushed at edge N appears on `ddr_write`/`ddr_writedata` no earlier than N+1.
- Throughput: one DDR write per cycle when `ddr_waitrequest`=0 and FIFO non-empty.
- Simultaneous push and pop on full FIFO: pop frees slot, push succeeds, no overflow.
- Simultaneous start and abort in one control write: abort wins if busy; start wins if idle.
- `done` asserts the cycle after the final completion; clears on next start or reset.

## Test plan
- One-shot: base=0x100, step=2, length=4, samples 1..4 back-to-back, waitrequest low → writes (0x100,1),(0x102,2),(0x104,3),(0x106,4); done=1; count=4; further samples ignored.
- Backpressure: waitrequest high 5 cycles on 2nd write → addr/data held stable throughout; all 4 samples written in order, no overflow.
- Overflow: FIFO_DEPTH=16, waitrequest high, 20 valid samples → overflow=1, first 16 samples written after release, last 4 lost.
- Circular: length=3, base=0x40, step=1, 7 samples → addresses 0x40,41,42,40,41,42,40; wrapped=1; busy stays 1.
- Abort mid-stall: abort while write pending with waitrequest high → write completes once waitrequest drops, no further writes, IDLE, aborted=1, done=0.
- Reset mid-RUN: rst_n low asynchronously → `ddr_write`=0 immediately, step reads back 1, status reads 0.
